// File: rtl/seq_div_16by8_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg: shared types and constants for the seq_div_16by8 divider.
//   state_e   - control FSM states (IDLE, RUN, DONE)
//   DIV_WIDTH - default divisor/quotient/remainder width (dividend is 2x)
//   DIV_CNT_W - iteration counter width, clog2(DIV_WIDTH)
//   ERR_FILL  - value driven on quotient/remainder for error results
// No ports (package).
// ---------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] ERR_FILL = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : div_pkg

// File: rtl/seq_div_16by8_if.sv
// ---------------------------------------------------------------------------
// seq_div_16by8_if: operand/result handshake bundle for the divider.
//   in_valid/in_ready   - operand request handshake (master -> divider)
//   dividend, divisor   - operands N (2*WIDTH bits) and D (WIDTH bits)
//   out_valid/out_ready - result handshake (divider -> master)
//   quotient, remainder - floor(N/D), N mod D
//   div_by_zero         - D was zero
//   overflow            - quotient would not fit in WIDTH bits
// Modports: master (operand source / result sink), slave (the divider).
// ---------------------------------------------------------------------------
interface seq_div_16by8_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

endinterface : seq_div_16by8_if

// File: rtl/seq_div_16by8_div_step.sv
// ---------------------------------------------------------------------------
// div_step: one radix-2 restoring division step, purely combinational.
//   rem_i     in  WIDTH  partial remainder, always < divisor_i
//   bit_i     in  1      next dividend bit shifted into the remainder
//   divisor_i in  WIDTH  denominator D
//   rem_o     out WIDTH  updated partial remainder (still < D)
//   q_o       out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // NOTE: combinational logic uses blocking '=' so later lines see the
  // values computed earlier in the same block; flops use '<=' only.
  always_comb begin
    partial = {rem_i, bit_i};
    diff    = partial - {1'b0, divisor_i};
    // Since rem_i < D, partial < 2*D fits WIDTH+1 bits and the MSB of the
    // difference is exactly the borrow: set means restore, clear means keep.
    q_o     = ~diff[WIDTH];
    rem_o   = q_o ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/seq_div_16by8.sv
// ---------------------------------------------------------------------------
// seq_div_16by8: sequential radix-2 restoring divider, 2*WIDTH / WIDTH.
// One quotient bit per clock; WIDTH RUN cycles per normal operation, error
// cases (D == 0, quotient overflow) complete the cycle after accept.
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset, aborts any operation
//   bus  slave modport of seq_div_16by8_if (operand / result handshakes)
// ---------------------------------------------------------------------------
module seq_div_16by8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  seq_div_16by8_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  // Datapath working registers.
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;

  logic               in_ready, out_valid;
  logic               in_dbz, in_ovf, last_step;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;

  assign in_dbz    = (bus.divisor == '0);
  // High half >= D means the true quotient needs more than WIDTH bits.
  assign in_ovf    = !in_dbz && (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
  assign last_step = (cnt_q == CNT_W'(WIDTH-1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (sreg_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  // NOTE: every comb output gets a default first, so no path through the
  // block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = (in_dbz || in_ovf) ? DONE : RUN;
      RUN:     if (last_step)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs (Moore, from state only).
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath / result next values.
  always_comb begin
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    rem_d       = rem_q;
    sreg_d      = sreg_q;
    divisor_d   = divisor_q;

    if (in_ready && bus.in_valid) begin
      divisor_d = bus.divisor;
      rem_d     = bus.dividend[2*WIDTH-1:WIDTH];
      sreg_d    = bus.dividend[WIDTH-1:0];
      cnt_d     = '0;
      if (in_dbz || in_ovf) begin
        quotient_d  = '1;
        remainder_d = '1;
        dbz_d       = in_dbz;
        ovf_d       = in_ovf;
      end
    end else if (state_q == RUN) begin
      rem_d  = step_rem;
      // Dividend bits leave at the MSB while quotient bits enter at the LSB;
      // after WIDTH steps the register holds the whole quotient.
      sreg_d = {sreg_q[WIDTH-2:0], step_q};
      cnt_d  = cnt_q + CNT_W'(1);
      if (last_step) begin
        quotient_d  = {sreg_q[WIDTH-2:0], step_q};
        remainder_d = step_rem;
        dbz_d       = 1'b0;
        ovf_d       = 1'b0;
      end
    end
  end

  // Visible result registers and counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: working registers carry no reset; they are always loaded at
  // accept before RUN reads them, so their power-up value never matters.
  always_ff @(posedge clk) begin
    rem_q     <= rem_d;
    sreg_q    <= sreg_d;
    divisor_q <= divisor_d;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;

endmodule : seq_div_16by8

// File: tb/tb_seq_div_16by8.sv
// ---------------------------------------------------------------------------
// tb_seq_div_16by8: directed vector table plus hand-written sequences for
// back-pressure and mid-operation reset, then a random sweep and a
// multiply-then-divide round trip.
// ---------------------------------------------------------------------------
module tb_seq_div_16by8;
  import div_pkg::*;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  seq_div_16by8_if bus ();

  seq_div_16by8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge where in_ready is expected high: presents operands
  // for one cycle, then scrambles them and counts cycles until out_valid.
  task automatic accept_and_wait(input logic [15:0] n, input logic [7:0] d, output int lat);
    check("pre_accept_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = n;
    bus.divisor  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.dividend = ~n;
    bus.divisor  = ~d;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] n, input logic [7:0] d, output int lat);
    @(negedge clk);
    accept_and_wait(n, d, lat);
  endtask

  function automatic logic [17:0] model(input logic [15:0] n, input logic [7:0] d);
    logic [15:0] q16, r16;
    if (d == 8'd0)            return {ERR_FILL, ERR_FILL, 1'b1, 1'b0};
    if (n[15:8] >= d)         return {ERR_FILL, ERR_FILL, 1'b0, 1'b1};
    q16 = n / {8'd0, d};
    r16 = n % {8'd0, d};
    return {q16[7:0], r16[7:0], 1'b0, 1'b0};
  endfunction

  function automatic logic [17:0] dut_result();
    return {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow};
  endfunction

  vec_t vecs [0:11];

  initial begin
    int lat;
    logic [17:0] held;
    int seen;
    logic [7:0] a, b;
    logic [15:0] p, rn;
    logic [7:0] rd;

    vecs = '{
      '{16'h7530, 8'h96, 8'hC8, 8'h00, 1'b0, 1'b0, 9},
      '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9},
      '{16'h7535, 8'h96, 8'hC8, 8'h05, 1'b0, 1'b0, 9},
      '{16'h1234, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1},
      '{16'h9600, 8'h96, 8'hFF, 8'hFF, 1'b0, 1'b1, 1},
      '{16'h0000, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 9},
      '{16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 9},
      '{16'h0100, 8'h01, 8'hFF, 8'hFF, 1'b0, 1'b1, 1},
      '{16'h00FF, 8'h10, 8'h0F, 8'h0F, 1'b0, 1'b0, 9},
      '{16'h0FFF, 8'h10, 8'hFF, 8'h0F, 1'b0, 1'b0, 9},
      '{16'hABCD, 8'hAC, 8'hFF, 8'h79, 1'b0, 1'b0, 9},
      '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9}
    };

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", 32'(dut_result()), 32'd0);
    rst = 1'b0;

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), 32'(dut_result()),
            32'({vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf}));
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 32'({bus.in_ready, bus.out_valid}), 32'b10);
      check($sformatf("vec%0d_retained", i), 32'(dut_result()),
            32'({vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].ovf}));
    end

    // Back-pressure: DONE held for 5 extra cycles with in_valid pulsing.
    bus.out_ready = 1'b0;
    run_op(16'h7535, 8'h96, lat);
    check("bp_latency", 32'(lat), 32'd9);
    held = dut_result();
    check("bp_result", 32'(held), 32'({8'hC8, 8'h05, 1'b0, 1'b0}));
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.dividend = 16'h0001;
      bus.divisor  = 8'h01;
      @(negedge clk);
      check($sformatf("bp_hold%0d_hs", k), 32'({bus.in_ready, bus.out_valid}), 32'b01);
      check($sformatf("bp_hold%0d_result", k), 32'(dut_result()), 32'(held));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    // Accept in the very first IDLE cycle after release.
    accept_and_wait(16'h7530, 8'h96, lat);
    check("bp_next_latency", 32'(lat), 32'd9);
    check("bp_next_result", 32'(dut_result()), 32'({8'hC8, 8'h00, 1'b0, 1'b0}));

    // Reset on the 4th RUN cycle aborts the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = 16'h7535;
    bus.divisor  = 8'h96;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("abort_result", 32'(dut_result()), 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_output", 32'(seen), 32'd0);
    accept_and_wait(16'h0064, 8'h07, lat);
    check("after_abort_latency", 32'(lat), 32'd9);
    check("after_abort_result", 32'(dut_result()), 32'({8'h0E, 8'h02, 1'b0, 1'b0}));

    // Random sweep against the arithmetic model.
    for (int k = 0; k < 1500; k++) begin
      rn = 16'($urandom);
      rd = (k % 4 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      if (k % 3 == 0) rn[15:8] = 8'($urandom_range(0, 32'(rd)));
      run_op(rn, rd, lat);
      check($sformatf("rand N=%h D=%h", rn, rd), 32'(dut_result()), 32'(model(rn, rd)));
    end

    // Multiplier round trip: (A*B)/B returns A with zero remainder.
    for (int k = 0; k < 500; k++) begin
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      p = {8'd0, a} * {8'd0, b};
      run_op(p, b, lat);
      check($sformatf("mul_chain A=%h B=%h", a, b), 32'(dut_result()),
            32'({a, 8'h00, 1'b0, 1'b0}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_div_16by8
